icache_dm: RTL

Parametrised direct-mapped instruction cache for each core. It sits between the core's fetch stage and the memory arbiter. Frame storage is an array of generalised tag/data/valid blocks with configurable set count and words per block. A fill state machine fetches missing blocks word by word through a wait-state handshake, supports a global flush, and keeps saturating hit/miss counters.

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/icache_frame.sv | 53 +++++
 rtl/icache_dm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core-side types: machine word and the instruction-cache fill state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE,
    FILL
  } icache_state_t;

endpackage

// File: rtl/icache_frame.sv
// One cache frame: valid bit, tag and a block of WORDS data words.
module icache_frame
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORDS = 2,
  parameter int unsigned TAGW  = 25
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    set_en,
  input  logic                    inv,
  input  logic [TAGW-1:0]         tag_in,
  input  word_t [WORDS-1:0]       data_in,
  output logic                    valid,
  output logic [TAGW-1:0]         tag,
  output word_t [WORDS-1:0]       data
);

  logic              valid_q, valid_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  word_t [WORDS-1:0] data_q, data_d;

  // Invalidate wins over a concurrent set so a flush never leaves a live frame.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv) begin
      valid_d = 1'b0;
    end else if (set_en) begin
      valid_d = 1'b1;
      tag_d   = tag_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign data  = data_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-by-word block refill,
// global flush and saturating hit/miss counters.
module icache_dm
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS  = 16,
  parameter int unsigned WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned OFF  = $clog2(WORDS);
  localparam int unsigned OFFW = (OFF == 0) ? 1 : OFF;
  localparam int unsigned TAGW = 30 - IDX - OFF;

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [IDX-1:0]   idx;
    logic [OFF+1:0]   low;
  } icache_addr_t;

  icache_addr_t      req;
  logic [OFFW-1:0]   req_off;

  logic              fr_valid [SETS];
  logic [TAGW-1:0]   fr_tag   [SETS];
  word_t [WORDS-1:0] fr_data  [SETS];
  logic [SETS-1:0]   fr_set;

  icache_state_t     state_q, state_d;
  logic [TAGW-1:0]   ftag_q, ftag_d;
  logic [IDX-1:0]    fidx_q, fidx_d;
  logic [OFFW-1:0]   cnt_q, cnt_d;
  word_t [WORDS-1:0] buf_q, buf_d;
  word_t             hit_count_q, hit_count_d;
  word_t             miss_count_q, miss_count_d;

  logic              hit, miss, accept, last, write_en;
  word_t [WORDS-1:0] fill_data;
  word_t [WORDS-1:0] sel_data;

  for (genvar s = 0; s < SETS; s++) begin : g_frame
    assign fr_set[s] = write_en && (fidx_q == IDX'(s));
    icache_frame #(
      .WORDS (WORDS),
      .TAGW  (TAGW)
    ) u_frame (
      .CLK     (CLK),
      .nRST    (nRST),
      .set_en  (fr_set[s]),
      .inv     (flush),
      .tag_in  (ftag_q),
      .data_in (fill_data),
      .valid   (fr_valid[s]),
      .tag     (fr_tag[s]),
      .data    (fr_data[s])
    );
  end

  always_comb begin
    req      = icache_addr_t'(imemaddr);
    req_off  = OFFW'(req.low >> 2);
    sel_data = fr_data[req.idx];
    hit      = (state_q == IDLE) && imemREN && !flush &&
               fr_valid[req.idx] && (fr_tag[req.idx] == req.tag);
    miss     = (state_q == IDLE) && imemREN && !flush && !hit;
    accept   = (state_q == FILL) && !iwait;
    last     = (cnt_q == OFFW'(WORDS - 1));
    // The final word goes straight from iload into the frame on the same edge.
    fill_data         = buf_q;
    fill_data[cnt_q]  = iload;
    write_en = accept && last && !flush;
  end

  always_comb begin
    state_d      = state_q;
    ftag_d       = ftag_q;
    fidx_d       = fidx_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    if (hit && (hit_count_q != '1))
      hit_count_d = hit_count_q + 32'd1;
    if (miss && (miss_count_q != '1))
      miss_count_d = miss_count_q + 32'd1;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            ftag_d  = req.tag;
            fidx_d  = req.idx;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            buf_d = fill_data;
            if (last) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + OFFW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      ftag_q       <= '0;
      fidx_q       <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ftag_q       <= ftag_d;
      fidx_q       <= fidx_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign ihit       = hit;
  assign imemload   = hit ? sel_data[req_off] : '0;
  assign iREN       = (state_q == FILL);
  assign iaddr      = (word_t'({ftag_q, fidx_q}) << (OFF + 2)) | (word_t'(cnt_q) << 2);
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
